// File: rtl/warships_pkg.sv
// Shared definitions for the warships game: click-decoder states and grid coordinates.
package warships_pkg;

  typedef enum logic [1:0] {
    GC_IDLE         = 2'd0,
    GC_LOCATE       = 2'd1,
    GC_OFFER        = 2'd2,
    GC_WAIT_RELEASE = 2'd3
  } grid_click_state_t;

  // Board cell coordinate as seen by the game FSM: {col, row}.
  typedef struct packed {
    logic [3:0] col;
    logic [3:0] row;
  } grid_cords_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous button plus a one-cycle rising-edge pulse.
// The edge output is blanked until the pipeline has been refilled from the real
// input after reset, so a button already held through reset never reads as a press.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic       meta_q;
  logic       sync_q;
  logic       dly_q;
  logic [2:0] warm_q;

  // Synchroniser chain, delay flop and post-reset fill tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
      warm_q <= 3'b000;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      warm_q <= {warm_q[1:0], 1'b1};
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~dly_q & warm_q[2];

endmodule

// File: rtl/grid_click_decoder.sv
// Turns a left-button press over the board grid into a {col,row} cell coordinate
// and offers it to the game controller over a valid/ready handshake.
module grid_click_decoder
  import warships_pkg::*;
#(
  parameter int X_POS     = 100,
  parameter int Y_POS     = 200,
  parameter int CELL_SIZE = 32,
  parameter int X_SIZE    = 10,
  parameter int Y_SIZE    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] mouse_x_pos,
  input  logic [11:0] mouse_y_pos,
  input  logic        mouse_left,
  input  logic        click_ready,
  output logic        click_valid,
  output logic [7:0]  click_cords,
  output logic        busy
);

  localparam int X_END = X_POS + X_SIZE * CELL_SIZE;
  localparam int Y_END = Y_POS + Y_SIZE * CELL_SIZE;
  localparam logic [11:0] CELL12 = 12'(CELL_SIZE);

  grid_click_state_t state_q, state_d;
  logic [11:0]       dx_q, dx_d;
  logic [11:0]       dy_q, dy_d;
  logic [3:0]        col_q, col_d;
  logic [3:0]        row_q, row_d;
  grid_cords_t       cords_q, cords_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic        left_s;
  logic        press;
  logic [31:0] x_ext;
  logic [31:0] y_ext;
  logic        in_grid;
  logic        dx_ge;
  logic        dy_ge;

  sync_edge_detect u_left_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (mouse_left),
    .level_o (left_s),
    .rise_o  (press)
  );

  assign x_ext   = {20'd0, mouse_x_pos};
  assign y_ext   = {20'd0, mouse_y_pos};
  assign in_grid = (x_ext >= 32'(X_POS)) && (x_ext < 32'(X_END)) &&
                   (y_ext >= 32'(Y_POS)) && (y_ext < 32'(Y_END));
  assign dx_ge   = (dx_q >= CELL12);
  assign dy_ge   = (dy_q >= CELL12);

  // State and datapath registers; outputs are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GC_IDLE;
      dx_q    <= 12'd0;
      dy_q    <= 12'd0;
      col_q   <= 4'd0;
      row_q   <= 4'd0;
      cords_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cords_q <= cords_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: capture offset, divide by repeated subtraction, offer, wait release.
  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    col_d   = col_q;
    row_d   = row_q;
    cords_d = cords_q;

    case (state_q)
      GC_IDLE: begin
        if (press && enable && in_grid) begin
          dx_d    = mouse_x_pos - 12'(X_POS);
          dy_d    = mouse_y_pos - 12'(Y_POS);
          col_d   = 4'd0;
          row_d   = 4'd0;
          state_d = GC_LOCATE;
        end
      end
      GC_LOCATE: begin
        if (!enable) begin
          state_d = GC_WAIT_RELEASE;
        end else begin
          if (dx_ge) begin
            dx_d  = dx_q - CELL12;
            col_d = col_q + 4'd1;
          end
          if (dy_ge) begin
            dy_d  = dy_q - CELL12;
            row_d = row_q + 4'd1;
          end
          if (!dx_ge && !dy_ge) begin
            cords_d.col = col_q;
            cords_d.row = row_q;
            state_d     = GC_OFFER;
          end
        end
      end
      GC_OFFER: begin
        // A ready in the same cycle as a dropped enable still completes the transfer.
        if (click_ready || !enable) begin
          state_d = GC_WAIT_RELEASE;
        end
      end
      GC_WAIT_RELEASE: begin
        if (!left_s) begin
          state_d = GC_IDLE;
        end
      end
      default: begin
        state_d = GC_IDLE;
      end
    endcase

    valid_d = (state_d == GC_OFFER);
    busy_d  = (state_d != GC_IDLE);
  end

  assign click_valid = valid_q;
  assign click_cords = cords_q;
  assign busy        = busy_q;

endmodule
